// File: rtl/word_pack_pkg.sv
// Shared types and helpers for the byte-to-word packer.
package word_pack_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {EMPTY, PART} pack_state_t;

  localparam byte_t DEFAULT_PAD_BYTE = 8'h00;

  // order 0: first byte lands in the upper lane; order 1: first byte in the lower lane.
  function automatic word_t merge_bytes(input byte_t first, input byte_t second, input logic order);
    return order ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/word_pack.sv
// Byte-to-word packer with a one-byte holding register and a one-word output register.
// Optional WORD_PACK_COUNT_EN adds out_count, a wrapping count of loaded words.
module word_pack
  import word_pack_pkg::*;
#(
  parameter int unsigned BYTE_ORDER = 0,
  parameter byte_t       PAD_BYTE   = DEFAULT_PAD_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  output logic              out_odd,
`ifdef WORD_PACK_COUNT_EN
  output logic [WORD_W-1:0] out_count,
`endif
  input  logic              out_ready
);

  localparam logic ORDER = (BYTE_ORDER != 0);

  pack_state_t state_q, state_d;
  byte_t       hold_q, hold_d;
  word_t       out_word_q, out_word_d;
  logic        out_valid_q, out_valid_d;
  logic        out_odd_q, out_odd_d;
  logic        word_would_form;
  logic        accept;
  logic        load;
`ifdef WORD_PACK_COUNT_EN
  word_t       count_q, count_d;
`endif

  // Next-state, handshake and output-register load logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    out_word_d  = out_word_q;
    out_odd_d   = out_odd_q;
    out_valid_d = out_valid_q;

    word_would_form = (state_q == PART) || in_last;
    // A byte that only fills hold_q never needs the output register.
    in_ready = !rst && !(word_would_form && out_valid_q && !out_ready);
    accept   = in_valid && in_ready;
    load     = accept && word_would_form;

    if (accept) begin
      if (state_q == PART) begin
        state_d    = EMPTY;
        out_word_d = merge_bytes(hold_q, in_byte, ORDER);
        out_odd_d  = 1'b0;
      end else if (in_last) begin
        out_word_d = merge_bytes(in_byte, PAD_BYTE, ORDER);
        out_odd_d  = 1'b1;
      end else begin
        state_d = PART;
        hold_d  = in_byte;
      end
    end

    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef WORD_PACK_COUNT_EN
  always_comb begin
    count_d = count_q + WORD_W'(load);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_odd_q   <= 1'b0;
`ifdef WORD_PACK_COUNT_EN
      count_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_odd_q   <= out_odd_d;
`ifdef WORD_PACK_COUNT_EN
      count_q     <= count_d;
`endif
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_odd   = out_odd_q;
`ifdef WORD_PACK_COUNT_EN
  assign out_count = count_q;
`endif

endmodule

// File: tb/tb_word_pack.sv
// Randomized and directed bench for word_pack; two instances (MSB-first/zero pad and
// LSB-first/0xA5 pad) share one input stream and are checked against a byte-pairing model.
module tb_word_pack;

  typedef struct {
    logic [7:0] f;
    logic [7:0] s;
    logic       odd;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic [15:0] out_word0, out_word1;
  logic        out_valid0, out_valid1;
  logic        out_odd0, out_odd1;
`ifdef WORD_PACK_COUNT_EN
  logic [15:0] out_count0, out_count1;
`endif

  int n_chk;
  int n_fail;

  // Model: pending first byte of a pair, queue of formed-but-unconsumed words.
  logic        m_hold;
  logic [7:0]  m_byte;
  logic        m_valid;
  logic [15:0] m_count;
  ent_t        exp_q[$];

  word_pack #(.BYTE_ORDER(0), .PAD_BYTE(8'h00)) dut0 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready0), .out_word(out_word0), .out_valid(out_valid0), .out_odd(out_odd0),
`ifdef WORD_PACK_COUNT_EN
    .out_count(out_count0),
`endif
    .out_ready(out_ready)
  );

  word_pack #(.BYTE_ORDER(1), .PAD_BYTE(8'hA5)) dut1 (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready1), .out_word(out_word1), .out_valid(out_valid1), .out_odd(out_odd1),
`ifdef WORD_PACK_COUNT_EN
    .out_count(out_count1),
`endif
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input ent_t e, input int order, input logic [7:0] pad);
    logic [7:0] s;
    s = e.odd ? pad : e.s;
    if (order == 0) return 16'(e.f * 256 + s);
    return 16'(s * 256 + e.f);
  endfunction

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic v, input logic [7:0] b, input logic l, input logic ordy,
                      input logic r, output logic rdy_seen);
    logic exp_rdy;
    ent_t e;
    in_valid = v; in_byte = b; in_last = l; out_ready = ordy; rst = r;
    #1;
    exp_rdy  = !r && !((m_hold || l) && m_valid && !ordy);
    rdy_seen = in_ready0;
    chk("in_ready0", 32'(in_ready0), 32'(exp_rdy));
    chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
    chk("out_valid0", 32'(out_valid0), 32'(m_valid));
    chk("out_valid1", 32'(out_valid1), 32'(m_valid));
    if (m_valid && exp_q.size() > 0) begin
      chk("out_word0", 32'(out_word0), 32'(exp_word(exp_q[0], 0, 8'h00)));
      chk("out_word1", 32'(out_word1), 32'(exp_word(exp_q[0], 1, 8'hA5)));
      chk("out_odd0", 32'(out_odd0), 32'(exp_q[0].odd));
      chk("out_odd1", 32'(out_odd1), 32'(exp_q[0].odd));
    end
`ifdef WORD_PACK_COUNT_EN
    chk("out_count0", 32'(out_count0), 32'(m_count));
    chk("out_count1", 32'(out_count1), 32'(m_count));
`endif
    if (r) begin
      m_hold = 1'b0; m_valid = 1'b0; m_count = '0;
      exp_q.delete();
    end else begin
      logic formed;
      formed = 1'b0;
      if (m_valid && ordy) void'(exp_q.pop_front());
      if (v && exp_rdy) begin
        if (m_hold) begin
          e.f = m_byte; e.s = b; e.odd = 1'b0;
          exp_q.push_back(e); m_hold = 1'b0; formed = 1'b1;
        end else if (l) begin
          e.f = b; e.s = 8'h00; e.odd = 1'b1;
          exp_q.push_back(e); formed = 1'b1;
        end else begin
          m_hold = 1'b1; m_byte = b;
        end
      end
      m_valid = formed || (m_valid && !ordy);
      if (formed) m_count = m_count + 16'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic rs;
    n_chk = 0; n_fail = 0;
    m_hold = 1'b0; m_byte = '0; m_valid = 1'b0; m_count = '0;
    rst = 1'b1; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, rs);
    chk("rst_rdy", 32'(rs), 32'h0);
    chk("rst_word", 32'(out_word0), 32'h0);
    chk("rst_odd", 32'(out_odd0), 32'h0);

    // Pair in both byte orders
    step(1'b1, 8'hAB, 1'b0, 1'b1, 1'b0, rs);
    step(1'b1, 8'hCD, 1'b0, 1'b1, 1'b0, rs);
    chk("pair_msb", 32'(out_word0), 32'h0000ABCD);
    chk("pair_lsb", 32'(out_word1), 32'h0000CDAB);
    chk("pair_valid", 32'(out_valid0), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, rs);
    chk("pair_one_cycle", 32'(out_valid0), 32'h0);

    // Odd stream end, then a full pair
    step(1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, rs);
    chk("odd_msb", 32'(out_word0), 32'h00005A00);
    chk("odd_lsb_pad", 32'(out_word1), 32'h0000A55A);
    chk("odd_flag", 32'(out_odd0), 32'h1);
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, rs);
    step(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, rs);
    chk("after_odd", 32'(out_word0), 32'h00001122);
    chk("after_odd_flag", 32'(out_odd0), 32'h0);

    // Backpressure
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, rs);
    chk("bp_first_rdy", 32'(rs), 32'h1);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, rs);
    chk("bp_second_stall", 32'(rs), 32'h0);
    chk("bp_hold_word", 32'(out_word0), 32'h00001122);
    step(1'b1, 8'h44, 1'b0, 1'b1, 1'b0, rs);
    chk("bp_release_rdy", 32'(rs), 32'h1);
    chk("bp_word", 32'(out_word0), 32'h00003344);
    chk("bp_word_lsb", 32'(out_word1), 32'h00004433);

    // Continuous stream
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0, rs);
    chk("stream_last", 32'(out_word0), 32'h00000708);

    // Reset mid-pair
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, rs);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, rs);
    chk("midrst_valid", 32'(out_valid0), 32'h0);
    chk("midrst_word", 32'(out_word0), 32'h0);
    step(1'b1, 8'h12, 1'b0, 1'b1, 1'b0, rs);
    step(1'b1, 8'h34, 1'b0, 1'b1, 1'b0, rs);
    chk("midrst_pair", 32'(out_word0), 32'h00001234);
`ifdef WORD_PACK_COUNT_EN
    chk("midrst_count", 32'(out_count0), 32'h1);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0, rs);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, rs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
